// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: instruction fetch from a loadable ROM, branch/halt decode, wrong-path squash and sticky halt
module fetch_decode_stage #(
    parameter int ADDR_W       = 8,
    parameter int INSTR_W      = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic               taken,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               lut_we,
    input  logic [3:0]         lut_idx,
    input  logic [7:0]         lut_data,
    output logic [INSTR_W-1:0] instr,
    output logic               valid,
    output logic               branchsig,
    output logic               branchtype,
    output logic [7:0]         BranchOut,
    output logic               halt
);
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    localparam logic [2:0]         ARM       = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);
    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(9'h0FF);

    logic [INSTR_W-1:0] rom [2**ADDR_W];
    logic [7:0]         lut [16];
    state_t             state;
    logic [2:0]         cnt;
    logic [2:0]         cnt_nxt;
    logic [INSTR_W-1:0] word;
    logic [2:0]         opc;
    logic               is_br;
    logic               is_bne;
    logic               is_halt;
    logic               squash;
    logic [7:0]         off;

    // decode the addressed word and work out squash and the next flush count
    always_comb begin
        word    = rom[pc_addr];
        opc     = word[INSTR_W-1 -: 3];
        is_br   = opc[2:1] == 2'b11;
        is_bne  = opc == 3'b111;
        is_halt = word == HALT_WORD;
        off     = is_br ? lut[word[3:0]] : 8'h00;
        squash  = (FLUSH_CYCLES != 0) && (taken || cnt != 3'd0);
        cnt_nxt = (FLUSH_CYCLES != 0 && taken) ? ARM : (cnt != 3'd0 ? cnt - 3'd1 : 3'd0);
    end

    // ROM is boot-loaded and deliberately not reset; reads see the pre-edge contents
    always_ff @(posedge clk) begin
        if (load_en) rom[load_addr] <= load_data;
    end

    // branch-offset table, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) lut[i] <= 8'h00;
        end else if (lut_we) begin
            lut[lut_idx] <= lut_data;
        end
    end

    // stage register, flush counter and halt latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr      <= '0;
            valid      <= 1'b0;
            branchsig  <= 1'b0;
            branchtype <= 1'b0;
            BranchOut  <= 8'h00;
            halt       <= 1'b0;
            cnt        <= 3'd0;
            state      <= RUN;
        end else if (state == HALTED) begin
            valid      <= 1'b0;
            branchsig  <= 1'b0;
            branchtype <= 1'b0;
            BranchOut  <= 8'h00;
        end else begin
            instr      <= word;
            valid      <= !squash;
            branchsig  <= !squash && is_br;
            branchtype <= !squash && is_br && is_bne;
            BranchOut  <= squash ? 8'h00 : off;
            cnt        <= cnt_nxt;
            if (!squash && is_halt) begin
                halt  <= 1'b1;
                state <= HALTED;
            end else begin
                state <= (cnt_nxt != 3'd0) ? FLUSH : RUN;
            end
        end
    end
endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Stage directly downstream of the program counter.
- Takes the registered 8-bit fetch address, reads the instruction ROM, and registers the instruction.
- Decodes the branch and halt controls that feed back into the PC: branchsig, branchtype, BranchOut, halt.
- Squashes wrong-path instructions for a fixed number of cycles after a taken branch, and latches the HALT state.

Parameters:
- ADDR_W, 8, fetch address width; ROM depth is 2^ADDR_W.
- INSTR_W, 9, instruction width.
- FLUSH_CYCLES, 2, number of slots squashed after a taken branch (0 to 7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_addr  in  ADDR_W  fetch address from the PC stage.
- taken  in  1  branch resolved taken this cycle.
- load_en  in  1  ROM write enable (test/boot load).
- load_addr  in  ADDR_W  ROM write address.
- load_data  in  INSTR_W  ROM write data.
- lut_we  in  1  branch-offset LUT write enable.
- lut_idx  in  4  LUT write index.
- lut_data  in  8  LUT write data (two's-complement offset).
- instr  out  INSTR_W  registered instruction.
- valid  out  1  instr is a live (non-squashed) instruction.
- branchsig  out  1  registered: instruction is a branch.
- branchtype  out  1  0 = blt, 1 = bne.
- BranchOut  out  8  registered branch offset from the LUT.
- halt  out  1  sticky halt indication.

Behaviour:
Storage:
- ROM: 2^ADDR_W x INSTR_W registers, not reset. Written at the clock edge when load_en=1, in any state.
- Read is combinational from pc_addr and feeds the stage register.
- Same-cycle write/read to one address: the capture sees the old data.
- LUT: 16 x 8 registers, reset to 0, written when lut_we=1.

Decode of the fetched word w (opc = w[8:6]):
- opc=3'b110: blt, so branch=1, btype=0.
- opc=3'b111: bne, so branch=1, btype=1.
- BranchOut = LUT[w[3:0]] for branches, else 0.
- w == 9'h0FF: halt instruction.
- All other words: branch=0, btype=0, no halt.

States (2-bit state plus 3-bit counter cnt): RUN, FLUSH, HALTED.
- squash = (FLUSH_CYCLES != 0) and (taken or cnt != 0).
- RUN/FLUSH, every edge:
  - instr <= rom[pc_addr].
  - valid <= !squash.
  - branchsig/branchtype/BranchOut <= decoded values when !squash, else 0.
- Counter:
  - taken=1 (and FLUSH_CYCLES != 0): cnt <= FLUSH_CYCLES-1.
  - else if cnt != 0: cnt <= cnt-1.
  - State is FLUSH whenever cnt != 0, else RUN.
  - Exactly FLUSH_CYCLES consecutive slots are squashed, counting the slot captured at the edge that samples taken.
- taken during FLUSH: restarts the count (re-arm).
- Halt capture: a halt word captured with !squash sets halt <= 1 and state <= HALTED.
  - The capture itself has valid=1 and branchsig=0.
  - A squashed halt word is ignored. taken plus a halt word in the same cycle: squash wins.
- HALTED:
  - instr is frozen; valid, branchsig, branchtype and BranchOut are 0; halt stays 1.
  - taken is ignored; ROM/LUT loads are still accepted.
  - Exit only by reset.
- Latency: 1 cycle from pc_addr to all registered outputs.
- Reset (asynchronous, any time, including mid-flush or while HALTED):
  - instr=0, valid=0, branchsig=0, branchtype=0, BranchOut=0, halt=0.
  - cnt=0, state=RUN, LUT=0. ROM is unchanged.

Test Plan:
- Load ROM[0..2] = 9'h000, 9'h1C5, 9'h0FF; LUT[5]=8'hFD; pc_addr 0,1,2 -> at cycles 1..3: valid=1; cycle 2 branchsig=1, branchtype=1, BranchOut=8'hFD; cycle 3 halt=1; afterwards HALTED with valid=0.
- FLUSH_CYCLES=2, taken pulsed at cycle 4 with ROM holding 9'h185 -> slots at edges 4 and 5 have valid=0, branchsig=0; edge 6 has valid=1, branchsig=1, branchtype=0.
- taken re-asserted one cycle into a flush -> squash extends to 3 consecutive slots total, then valid=1.
- Halt word at pc_addr on the same edge taken=1 -> halt stays 0, valid=0; the next unsquashed halt word sets halt=1.
- In HALTED, toggle taken and pc_addr for 10 cycles -> all outputs frozen; then assert reset asynchronously between edges -> all outputs 0 immediately, fetch resumes at the next edge.
- FLUSH_CYCLES=0 variant: taken every cycle -> valid=1 on every capture, no squashing.
